// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter sitting on the core's data-memory
//   port. Stores to TXDATA push a byte into a small TX FIFO. A serializer
//   drains the FIFO onto the Tx line, LSB first, with one start bit and
//   one stop bit. Status and control read back combinationally.
//
//   Register map (offset = Addr[3:2]):
//     0 TXDATA  write pushes WriteData[7:0], reads 0
//     1 STATUS  bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky,
//               write 1 to bit3 to clear), bits[8+DEPTH_LOG2:8] count
//     2 CTRL    bit0 enable
//     3 -       reserved, reads 0
//
//   Ports:
//     Clk        rising-edge clock
//     Reset      asynchronous active-low reset
//     Addr       byte address from the memory stage
//     WriteData  store data
//     MemWrite   store strobe
//     ReadData   combinational register read data (valid when Hit=1)
//     Hit        combinational: Addr inside the 16-byte region
//     Tx         serial line, registered, idles high
//     Busy       registered: serializer not idle
//
//   Serializer states:
//     state | meaning
//     IDLE  | line high, waiting for enable && FIFO not empty
//     START | start bit (line low) for CLKS_PER_BIT cycles
//     DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
//     STOP  | stop bit (line high); may pop the next byte on its last cycle

module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DEPTH_LOG2   = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        Tx,
  output logic        Busy
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]   BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // ------------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------------
  logic [1:0] reg_sel;
  logic       wr_en;
  logic       wr_txdata;
  logic       wr_status;
  logic       wr_ctrl;

  assign Hit       = (Addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel   = Addr[3:2];
  assign wr_en     = MemWrite && Hit;
  assign wr_txdata = wr_en && (reg_sel == 2'd0);
  assign wr_status = wr_en && (reg_sel == 2'd1);
  assign wr_ctrl   = wr_en && (reg_sel == 2'd2);

  // Only the bits that map onto a register field are consumed.
  logic unused_bits;
  assign unused_bits = ^{WriteData[31:8], Addr[1:0]};

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  logic [7:0]            fifo_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  enable_q, enable_d;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [7:0]            fifo_head;

  // Fullness and emptiness are judged on the pre-edge count, so a push
  // into a full FIFO is dropped even if the serializer pops this cycle.
  assign fifo_full  = (count_q == COUNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign push       = wr_txdata && !fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr_q];

  // ------------------------------------------------------------------
  // FIFO and control register next-state
  // ------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    enable_d   = enable_q;

    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase

    if (wr_txdata && fifo_full) begin
      overflow_d = 1'b1;
    end else if (wr_status && WriteData[3]) begin
      overflow_d = 1'b0;
    end

    if (wr_ctrl) enable_d = WriteData[0];
  end

  // Storage has no reset; only pointers and count define its contents.
  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr_q] <= WriteData[7:0];
  end

  // ------------------------------------------------------------------
  // Serializer next-state
  // ------------------------------------------------------------------
  logic baud_last;
  logic can_pop;

  assign baud_last = (baud_q == BAUD_LAST);
  assign can_pop   = enable_q && !fifo_empty;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        baud_d    = '0;
        bit_idx_d = '0;
        if (can_pop) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_STOP: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          // Chaining straight into the next start bit keeps frames gapless.
          if (can_pop) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Tx and Busy are registered copies of what the next state drives,
    // so the line changes on the same edge as the state.
    unique case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      enable_q   <= 1'b1;
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      enable_q   <= enable_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign Tx   = tx_q;
  assign Busy = busy_q;

  // ------------------------------------------------------------------
  // Read path
  // ------------------------------------------------------------------
  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    unique case (reg_sel)
      2'd1: begin
        rd_data[0]                  = fifo_full;
        rd_data[1]                  = fifo_empty;
        rd_data[2]                  = busy_q;
        rd_data[3]                  = overflow_q;
        rd_data[8 +: DEPTH_LOG2 + 1] = count_q;
      end
      2'd2:    rd_data[0] = enable_q;
      default: rd_data = '0;
    endcase
  end

  assign ReadData = Hit ? rd_data : 32'h0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DL2   = 2;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] A_TX = 32'h1000_0000;
  localparam logic [31:0] A_ST = 32'h1000_0004;
  localparam logic [31:0] A_CT = 32'h1000_0008;
  localparam logic [31:0] A_RS = 32'h1000_000C;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] Addr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic        MemWrite = 1'b0;
  logic [31:0] ReadData;
  logic        Hit;
  logic        Tx;
  logic        Busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  mmio_uart_tx #(
    .BASE_ADDR   (32'h1000_0000),
    .CLKS_PER_BIT(CPB),
    .DEPTH_LOG2  (DL2)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Addr     (Addr),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .ReadData (ReadData),
    .Hit      (Hit),
    .Tx       (Tx),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // Line level of bit idx (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    return fr[idx];
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    Addr = a; WriteData = d; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0; Addr = 32'h0; WriteData = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    Addr = a;
    #1;
    d = ReadData;
    h = Hit;
    Addr = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic h;
    Reset = 1'b0;
    repeat (3) tick();
    vectors++;
    if (Tx !== 1'b1) begin miscompares++; $display("FAIL rst_tx_held: got %b expected 1", Tx); end
    Reset = 1'b1;
    tick();
    bus_read(A_ST, d, h);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL rst_status: got %h expected 00000002", d); end
    vectors++;
    if (h !== 1'b1) begin miscompares++; $display("FAIL rst_hit: got %b expected 1", h); end
    vectors++;
    if (Tx !== 1'b1 || Busy !== 1'b0) begin
      miscompares++; $display("FAIL rst_line: got tx=%b busy=%b expected tx=1 busy=0", Tx, Busy);
    end
    bus_read(A_CT, d, h);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL rst_ctrl: got %h expected 00000001", d); end
    bus_read(32'h2000_0000, d, h);
    vectors++;
    if (h !== 1'b0) begin miscompares++; $display("FAIL miss_hit: got %b expected 0", h); end
    bus_read(A_RS, d, h);
    vectors++;
    if (d !== 32'h0 || h !== 1'b1) begin
      miscompares++; $display("FAIL reserved_read: got %h hit=%b expected 00000000 hit=1", d, h);
    end
    bus_read(A_TX, d, h);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL txdata_read: got %h expected 00000000", d); end
  endtask

  task automatic test_single_frame();
    logic [31:0] d;
    logic h;
    int k;
    logic [7:0] b;
    b = 8'hA5;
    bus_write(A_TX, 32'hABCD_E5A5);
    k = cyc;
    vectors++;
    if (Tx !== 1'b1 || Busy !== 1'b0) begin
      miscompares++; $display("FAIL single_pre: got tx=%b busy=%b expected tx=1 busy=0", Tx, Busy);
    end
    bus_read(A_ST, d, h);
    vectors++;
    if (d !== 32'h100) begin miscompares++; $display("FAIL single_count1: got %h expected 00000100", d); end
    for (int i = 0; i < 10; i++) begin
      wait_cyc(k + 1 + CPB * i);
      vectors++;
      if (Tx !== frame_bit(b, i)) begin
        miscompares++; $display("FAIL single_bit%0d: got %b expected %b", i, Tx, frame_bit(b, i));
      end
      if (i == 0) begin
        vectors++;
        if (Busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_rise: got %b expected 1", Busy); end
        bus_read(A_ST, d, h);
        vectors++;
        if (d !== 32'h6) begin miscompares++; $display("FAIL single_popped: got %h expected 00000006", d); end
      end
    end
    wait_cyc(k + FRAME);
    vectors++;
    if (Busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_last: got %b expected 1", Busy); end
    wait_cyc(k + FRAME + 1);
    vectors++;
    if (Busy !== 1'b0 || Tx !== 1'b1) begin
      miscompares++; $display("FAIL single_end: got tx=%b busy=%b expected tx=1 busy=0", Tx, Busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic h;
    int k;
    logic [7:0] q[$];
    q = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    k = cyc + 1;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          Addr = A_TX; WriteData = 32'h11 + i; MemWrite = 1'b1;
          tick();
        end
        MemWrite = 1'b0; Addr = 32'h0;
        bus_read(A_ST, d, h);
        vectors++;
        if (d !== 32'h405) begin miscompares++; $display("FAIL b2b_full: got %h expected 00000405", d); end
        bus_write(A_TX, 32'h0000_0099);
        bus_read(A_ST, d, h);
        vectors++;
        if (d !== 32'h40D) begin miscompares++; $display("FAIL b2b_overflow: got %h expected 0000040d", d); end
      end
      begin
        for (int c = k + 6; c <= k + 1 + 5 * FRAME; c++) begin
          int rel;
          logic ex_tx, ex_busy;
          wait_cyc(c);
          rel = c - (k + 1);
          if (rel < 5 * FRAME) begin
            ex_tx = frame_bit(q[rel / FRAME], (rel % FRAME) / CPB);
            ex_busy = 1'b1;
          end else begin
            ex_tx = 1'b1;
            ex_busy = 1'b0;
          end
          vectors++;
          if (Tx !== ex_tx || Busy !== ex_busy) begin
            miscompares++;
            $display("FAIL b2b_line@%0d: got tx=%b busy=%b expected tx=%b busy=%b", rel, Tx, Busy, ex_tx, ex_busy);
          end
        end
      end
    join
  endtask

  task automatic test_overflow_clear();
    logic [31:0] d;
    logic h;
    bus_read(A_ST, d, h);
    vectors++;
    if (d !== 32'hA) begin miscompares++; $display("FAIL ovf_sticky: got %h expected 0000000a", d); end
    bus_write(A_ST, 32'h0);
    bus_read(A_ST, d, h);
    vectors++;
    if (d !== 32'hA) begin miscompares++; $display("FAIL ovf_write0: got %h expected 0000000a", d); end
    bus_write(A_ST, 32'h8);
    bus_read(A_ST, d, h);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL ovf_clear: got %h expected 00000002", d); end
  endtask

  task automatic test_enable();
    logic [31:0] d;
    logic h;
    int k, m;
    logic [7:0] q[$];
    q = {8'h3C, 8'hC3, 8'h5E};
    k = cyc + 1;
    fork
      begin
        bus_write(A_TX, 32'h3C);
        bus_write(A_TX, 32'hC3);
        bus_write(A_TX, 32'h5E);
        wait_cyc(k + 10);
        bus_write(A_CT, 32'h0);
      end
      begin
        for (int c = k + 1; c <= k + FRAME + 20; c++) begin
          int rel;
          logic ex_tx, ex_busy;
          wait_cyc(c);
          rel = c - (k + 1);
          if (rel < FRAME) begin
            ex_tx = frame_bit(q[0], rel / CPB);
            ex_busy = 1'b1;
          end else begin
            ex_tx = 1'b1;
            ex_busy = 1'b0;
          end
          vectors++;
          if (Tx !== ex_tx || Busy !== ex_busy) begin
            miscompares++;
            $display("FAIL en_off_line@%0d: got tx=%b busy=%b expected tx=%b busy=%b", rel, Tx, Busy, ex_tx, ex_busy);
          end
        end
      end
    join
    bus_read(A_ST, d, h);
    vectors++;
    if (d !== 32'h200) begin miscompares++; $display("FAIL en_off_count: got %h expected 00000200", d); end
    bus_read(A_CT, d, h);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL en_off_ctrl: got %h expected 00000000", d); end
    bus_write(A_CT, 32'h1);
    m = cyc;
    vectors++;
    if (Tx !== 1'b1 || Busy !== 1'b0) begin
      miscompares++; $display("FAIL en_on_edge: got tx=%b busy=%b expected tx=1 busy=0", Tx, Busy);
    end
    for (int c = m + 1; c <= m + 1 + 2 * FRAME; c++) begin
      int rel;
      logic ex_tx, ex_busy;
      wait_cyc(c);
      rel = c - (m + 1);
      if (rel < 2 * FRAME) begin
        ex_tx = frame_bit(q[1 + rel / FRAME], (rel % FRAME) / CPB);
        ex_busy = 1'b1;
      end else begin
        ex_tx = 1'b1;
        ex_busy = 1'b0;
      end
      vectors++;
      if (Tx !== ex_tx || Busy !== ex_busy) begin
        miscompares++;
        $display("FAIL en_on_line@%0d: got tx=%b busy=%b expected tx=%b busy=%b", rel, Tx, Busy, ex_tx, ex_busy);
      end
    end
    bus_read(A_ST, d, h);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL en_drained: got %h expected 00000002", d); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic h;
    for (int it = 0; it < 3; it++) begin
      int k, n;
      logic [7:0] q[$];
      int gaps[$];
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        q.push_back(8'($urandom));
        gaps.push_back($urandom_range(0, 2));
      end
      k = cyc + 1;
      fork
        begin
          for (int i = 0; i < n; i++) begin
            bus_write(A_TX, {24'($urandom), q[i]});
            repeat (gaps[i]) tick();
          end
        end
        begin
          for (int c = k + 1; c <= k + 1 + n * FRAME; c++) begin
            int rel;
            logic ex_tx, ex_busy;
            wait_cyc(c);
            rel = c - (k + 1);
            if (rel < n * FRAME) begin
              ex_tx = frame_bit(q[rel / FRAME], (rel % FRAME) / CPB);
              ex_busy = 1'b1;
            end else begin
              ex_tx = 1'b1;
              ex_busy = 1'b0;
            end
            vectors++;
            if (Tx !== ex_tx || Busy !== ex_busy) begin
              miscompares++;
              $display("FAIL rand%0d_line@%0d: got tx=%b busy=%b expected tx=%b busy=%b", it, rel, Tx, Busy, ex_tx, ex_busy);
            end
          end
        end
      join
      bus_read(A_ST, d, h);
      vectors++;
      if (d !== 32'h2) begin miscompares++; $display("FAIL rand%0d_status: got %h expected 00000002", it, d); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic h;
    int k;
    k = cyc + 1;
    bus_write(A_TX, 32'h00);
    bus_write(A_TX, 32'h77);
    wait_cyc(k + 1 + CPB * 4 + 1);
    vectors++;
    if (Tx !== 1'b0 || Busy !== 1'b1) begin
      miscompares++; $display("FAIL mid_pre: got tx=%b busy=%b expected tx=0 busy=1", Tx, Busy);
    end
    Reset = 1'b0;
    #1;
    vectors++;
    if (Tx !== 1'b1 || Busy !== 1'b0) begin
      miscompares++; $display("FAIL mid_async: got tx=%b busy=%b expected tx=1 busy=0", Tx, Busy);
    end
    bus_read(A_ST, d, h);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL mid_status: got %h expected 00000002", d); end
    tick();
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      vectors++;
      if (Tx !== 1'b1 || Busy !== 1'b0) begin
        miscompares++; $display("FAIL mid_after@%0d: got tx=%b busy=%b expected tx=1 busy=0", i, Tx, Busy);
      end
    end
    bus_read(A_ST, d, h);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL mid_final_status: got %h expected 00000002", d); end
    bus_read(A_CT, d, h);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL mid_final_ctrl: got %h expected 00000001", d); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow_clear();
    test_enable();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
